// File: rtl/score_palette_pipe.sv
// score_palette_pipe: two-stage pixel colour mapper for the score display path.
// Instrument colours come from a register-writable palette with write-first bypass.
// Optional feature macro: COLOR_BLINK_EN (frame-counted blinking of cursor pixels).
module score_palette_pipe #(
  parameter int unsigned NUM_INSTR    = 4,
  parameter int unsigned INSTR_W      = 2,
  parameter int unsigned COLOR_W      = 8,
  parameter int unsigned BLINK_PERIOD = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pix_valid_in,
  input  logic [1:0]             pixel_type,
  input  logic [INSTR_W-1:0]     instrument_type,
  input  logic                   frame_start,
  input  logic                   pal_we,
  input  logic [INSTR_W-1:0]     pal_addr,
  input  logic [3*COLOR_W-1:0]   pal_wdata,
  output logic                   pix_valid_out,
  output logic [COLOR_W-1:0]     r,
  output logic [COLOR_W-1:0]     g,
  output logic [COLOR_W-1:0]     b
);

  localparam int unsigned RGB_W = 3 * COLOR_W;

  localparam logic [COLOR_W-1:0] C_ON  = '1;
  localparam logic [COLOR_W-1:0] C_OFF = '0;
  localparam logic [RGB_W-1:0]   WHITE = '1;
  localparam logic [RGB_W-1:0]   BLACK = '0;

  localparam logic [1:0] PT_NOTE   = 2'b00;
  localparam logic [1:0] PT_STAFF  = 2'b01;
  localparam logic [1:0] PT_CURSOR = 2'b10;

  // Power-up palette: red, green, blue, then white for any further entries
  function automatic logic [RGB_W-1:0] reset_color(input int unsigned idx);
    case (idx)
      32'd0:   return {C_ON,  C_OFF, C_OFF};
      32'd1:   return {C_OFF, C_ON,  C_OFF};
      32'd2:   return {C_OFF, C_OFF, C_ON};
      default: return {C_ON,  C_ON,  C_ON};
    endcase
  endfunction

  logic [RGB_W-1:0] palette_q [NUM_INSTR];
  logic [RGB_W-1:0] palette_d [NUM_INSTR];
  logic [RGB_W-1:0] lookup_c;
  logic [RGB_W-1:0] cursor_c;

  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_type_q,  s1_type_d;
  logic [RGB_W-1:0] s1_color_q, s1_color_d;

  logic             valid_out_q, valid_out_d;
  logic [RGB_W-1:0] rgb_q,       rgb_d;

`ifdef COLOR_BLINK_EN
  localparam int unsigned CNT_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_PERIOD - 1);

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             s1_phase_q, s1_phase_d;

  // Frame counter: wraps every BLINK_PERIOD frame_start pulses, flipping the blink phase
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

  // Blink state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      s1_phase_q    <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      s1_phase_q    <= s1_phase_d;
    end
  end

  // Cursor pixels go dark during the odd blink phase
  always_comb begin
    cursor_c = s1_phase_q ? BLACK : WHITE;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{frame_start, 32'(BLINK_PERIOD)};

  // Without blinking the cursor is always white
  always_comb begin
    cursor_c = WHITE;
  end
`endif

  // Palette next state: writes to entries beyond NUM_INSTR match no entry and are dropped
  always_comb begin
    for (int unsigned i = 0; i < NUM_INSTR; i++) begin
      palette_d[i] = palette_q[i];
      if (pal_we && (pal_addr == INSTR_W'(i))) begin
        palette_d[i] = pal_wdata;
      end
    end
  end

  // Lookup reads the post-write palette so a same-cycle write is seen (write-first)
  always_comb begin
    lookup_c = BLACK;
    for (int unsigned i = 0; i < NUM_INSTR; i++) begin
      if (instrument_type == INSTR_W'(i)) begin
        lookup_c = palette_d[i];
      end
    end
  end

  // Stage 1 capture: payload only loads on valid pixels
  always_comb begin
    s1_valid_d = pix_valid_in;
    s1_type_d  = s1_type_q;
    s1_color_d = s1_color_q;
`ifdef COLOR_BLINK_EN
    s1_phase_d = s1_phase_q;
`endif
    if (pix_valid_in) begin
      s1_type_d  = pixel_type;
      s1_color_d = lookup_c;
`ifdef COLOR_BLINK_EN
      // Phase before this cycle's frame_start takes effect
      s1_phase_d = blink_phase_q;
`endif
    end
  end

  // Stage 2 colour resolve: output colour holds across invalid cycles
  always_comb begin
    valid_out_d = s1_valid_q;
    rgb_d       = rgb_q;
    if (s1_valid_q) begin
      case (s1_type_q)
        PT_NOTE:   rgb_d = s1_color_q;
        PT_STAFF:  rgb_d = WHITE;
        PT_CURSOR: rgb_d = cursor_c;
        default:   rgb_d = BLACK;
      endcase
    end
  end

  // Palette and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_INSTR; i++) begin
        palette_q[i] <= reset_color(i);
      end
      s1_valid_q  <= 1'b0;
      s1_type_q   <= 2'b00;
      s1_color_q  <= '0;
      valid_out_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_INSTR; i++) begin
        palette_q[i] <= palette_d[i];
      end
      s1_valid_q  <= s1_valid_d;
      s1_type_q   <= s1_type_d;
      s1_color_q  <= s1_color_d;
      valid_out_q <= valid_out_d;
      rgb_q       <= rgb_d;
    end
  end

  assign pix_valid_out = valid_out_q;
  assign r             = rgb_q[RGB_W-1 -: COLOR_W];
  assign g             = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign b             = rgb_q[COLOR_W-1:0];

endmodule

// File: doc/score_palette_pipe.md
Name: score_palette_pipe

Overview:
Pipelined, parametrised pixel colour mapper for the score display path. It replaces fixed combinational colouring with a register-writable palette of NUM_INSTR instrument colours and a 2-stage registered pixel pipeline carrying a valid flag. It sits between the score pixel classifier (pixel_type / instrument_type source) and the video output stage.

Parameters:
NUM_INSTR, 4, number of palette entries (instrument colours); must be 2..(2**INSTR_W)
INSTR_W, 2, width of instrument_type and pal_addr
COLOR_W, 8, bits per colour channel
BLINK_PERIOD, 30, frames per blink half-cycle (used only with COLOR_BLINK_EN); must be >=1

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
pix_valid_in  in  1  pixel_type / instrument_type valid this cycle
pixel_type  in  2  00 instrument note, 01 staff line, 10 cursor/highlight, 11 background
instrument_type  in  INSTR_W  palette index for pixel_type 00
frame_start  in  1  one-cycle pulse at start of each video frame
pal_we  in  1  palette write strobe
pal_addr  in  INSTR_W  palette write index
pal_wdata  in  3*COLOR_W  {r,g,b} write data
pix_valid_out  out  1  r/g/b valid
r  out  COLOR_W  red
g  out  COLOR_W  green
b  out  COLOR_W  blue

Behaviour:
- Reset (rst_n low, async assert; deassertion is synchronous to clk): pix_valid_out=0, r=g=b=0, both pipeline stages invalid; palette entry 0=red {all-ones,0,0}, 1=green, 2=blue, entries >=3 white (all ones); blink counter and phase=0.
- Reset mid-stream: in-flight pixels are discarded; no pix_valid_out for 2 cycles after the first valid input following reset.
- Pipeline: stage 1 registers valid, pixel_type and the palette lookup result; stage 2 resolves the final colour and registers r/g/b and pix_valid_out. Latency is exactly 2 cycles, throughput 1 pixel/cycle, and there is no back-pressure.
- Colour select at stage 2:
  - pixel_type 00: palette[instrument_type]; if instrument_type >= NUM_INSTR, output black.
  - pixel_type 01: white.
  - pixel_type 10: white (see Optional Feature).
  - pixel_type 11: black.
- Invalid pixels: when pix_valid_in=0 the stage valid is 0. r/g/b hold their last values, i.e. the output registers update only on valid.
- Palette write: on a clk edge with pal_we=1, palette[pal_addr] <= pal_wdata. Writes with pal_addr >= NUM_INSTR are ignored. Writes are accepted regardless of pix_valid_in.
- Write/read collision: if pal_we and a valid pixel_type 00 lookup of the same index occur in the same cycle, the lookup returns pal_wdata (write-first bypass).
- Channel packing: pal_wdata[3*COLOR_W-1 -: COLOR_W]=r, middle field=g, LSB field=b.

Optional Feature:
COLOR_BLINK_EN
- Defined:
  - A frame counter counts frame_start pulses from 0 to BLINK_PERIOD-1 and then wraps to 0, toggling blink_phase on each wrap.
  - pixel_type 10 outputs white when blink_phase=0 and black when blink_phase=1.
  - A frame_start coinciding with a valid pixel affects only pixels entering stage 1 on the following cycle.
- Undefined: no counter or phase register exists, frame_start is ignored, and pixel_type 10 is always white.

Test Plan:
1. Reset values: assert rst_n=0 mid-stream -> pix_valid_out=0 and rgb=000000 immediately. Then release reset and feed pixel_type 00 with instrument 0,1,2,3 on consecutive cycles -> 2 cycles later, outputs FF0000, 00FF00, 0000FF, FFFFFF on consecutive cycles.
2. Fixed types: feed valid pixel_type 01/10/11 -> FFFFFF, FFFFFF, 000000 at latency 2. pix_valid_in toggling 1,0,1 -> pix_valid_out 1,0,1 delayed 2 cycles, with rgb held during the gap.
3. Palette write: pal_we, addr 1, data 123456 -> a subsequent type 00 / instrument 1 pixel gives 123456. A write to addr 1 in the same cycle as an instrument 1 lookup with data ABCDEF -> output ABCDEF (bypass).
4. Out-of-range: with NUM_INSTR=3, instrument_type 3 -> 000000. A write to addr 3 is ignored, so a later instrument 0 read is unchanged.
5. Streaming: 64 back-to-back valid pixels with random types -> output matches a reference model, 2-cycle latency, no dropped pixels.
6. (COLOR_BLINK_EN, BLINK_PERIOD=2) Stream pixel_type 10 across 6 frame_start pulses -> white for 2 frames, black for 2 frames, white for 2 frames.
